nebula_noc_mem_target: RTL and testbench

NoC-side memory target that consumes the request stream produced by `nebula_axi_if` (`noc_req_*`) and returns the matching response stream (`noc_resp_*`). It decodes read/write requests, performs them on a local word-organised SRAM model with byte strobes, and returns in-order responses carrying the request's packet ID after a fixed pipeline latency. A credit-limited response FIFO applies backpressure. Flit packing and unpacking to and from `noc_flit_t` is done by the tile wrapper; this block sees flat fields.

---
 rtl/nebula_noc_mem_target.sv | 246 ++++++++++++++++++++++++
 tb/tb_nebula_noc_mem_target.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nebula_noc_mem_target.sv
// nebula_noc_mem_target
//
// NoC-side memory target. It accepts flat read/write requests, performs them
// on a local word-organised SRAM with byte strobes, and returns in-order
// responses that echo the packet ID after a fixed pipeline latency.
// Credits that cover the delay pipeline plus the response FIFO keep the
// FIFO from ever overflowing.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   noc_req_valid / noc_req_ready  request handshake (ready from registered state only)
//   noc_req_write/addr/id/data/strb  request fields
//   noc_resp_valid / noc_resp_ready  response handshake
//   noc_resp_id/write/data/err     response fields (all zero while not valid)
//   inflight                       requests accepted and not yet popped
//   req_count                      accepted requests, wrapping
//   err_count                      error responses issued, saturating
module nebula_noc_mem_target #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          noc_req_valid,
  output logic                          noc_req_ready,
  input  logic                          noc_req_write,
  input  logic [ADDR_WIDTH-1:0]         noc_req_addr,
  input  logic [ID_WIDTH-1:0]           noc_req_id,
  input  logic [DATA_WIDTH-1:0]         noc_req_data,
  input  logic [DATA_WIDTH/8-1:0]       noc_req_strb,
  output logic                          noc_resp_valid,
  input  logic                          noc_resp_ready,
  output logic [ID_WIDTH-1:0]           noc_resp_id,
  output logic                          noc_resp_write,
  output logic [DATA_WIDTH-1:0]         noc_resp_data,
  output logic [1:0]                    noc_resp_err,
  output logic [$clog2(RESP_DEPTH):0]   inflight,
  output logic [31:0]                   req_count,
  output logic [15:0]                   err_count
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic             accept;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;

  // Byte-offset bits select nothing inside a word.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, noc_req_addr[OFS-1:0]};

  assign req_idx = noc_req_addr[OFS +: IDX_W];
  // Any address bit above the word index means the access is out of range.
  assign req_err = |(noc_req_addr >> (OFS + IDX_W));

  // ---------------------------------------------------------------------
  // Memory: not reset. The read register is sampled on the acceptance edge,
  // so a read the cycle after a write to the same word sees the new data.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (accept && noc_req_write && !req_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (noc_req_strb[b]) begin
          mem[req_idx][b*8 +: 8] <= noc_req_data[b*8 +: 8];
        end
      end
    end
    if (accept && !noc_req_write) begin
      rdata_q <= mem[req_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Delay pipeline. Stage 0 is captured together with the memory read
  // register; the last stage pushes into the FIFO on the next edge, giving
  // LATENCY edges from accept to response-valid.
  // ---------------------------------------------------------------------
  logic                pipe_valid_q [LATENCY];
  logic                pipe_valid_d [LATENCY];
  logic                pipe_write_q [LATENCY];
  logic                pipe_write_d [LATENCY];
  logic                pipe_err_q   [LATENCY];
  logic                pipe_err_d   [LATENCY];
  logic [ID_WIDTH-1:0] pipe_id_q    [LATENCY];
  logic [ID_WIDTH-1:0] pipe_id_d    [LATENCY];

  always_comb begin
    pipe_valid_d[0] = accept;
    pipe_write_d[0] = noc_req_write;
    pipe_err_d[0]   = req_err;
    pipe_id_d[0]    = noc_req_id;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_write_d[i] = pipe_write_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_id_d[i]    = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_write_q[i] <= 1'b0;
        pipe_err_q[i]   <= 1'b0;
        pipe_id_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_write_q[i] <= pipe_write_d[i];
        pipe_err_q[i]   <= pipe_err_d[i];
        pipe_id_q[i]    <= pipe_id_d[i];
      end
    end
  end

  // Writes and errors carry zero data; only clean reads expose the RAM word.
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  assign head_data = (pipe_write_q[0] || pipe_err_q[0]) ? '0 : rdata_q;

  generate
    if (LATENCY > 1) begin : g_dpipe
      logic [DATA_WIDTH-1:0] dpipe_q [1:LATENCY-1];
      logic [DATA_WIDTH-1:0] dpipe_d [1:LATENCY-1];

      always_comb begin
        dpipe_d[1] = head_data;
        for (int i = 2; i < LATENCY; i++) begin
          dpipe_d[i] = dpipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 1; i < LATENCY; i++) begin
            dpipe_q[i] <= '0;
          end
        end else begin
          for (int i = 1; i < LATENCY; i++) begin
            dpipe_q[i] <= dpipe_d[i];
          end
        end
      end

      assign tail_data = dpipe_q[LATENCY-1];
    end else begin : g_no_dpipe
      assign tail_data = head_data;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Response FIFO. Storage is not reset; outputs are gated by valid so they
  // read as zero whenever the FIFO is empty (including straight out of reset).
  // ---------------------------------------------------------------------
  logic [ID_WIDTH-1:0]   fifo_id_q    [RESP_DEPTH];
  logic                  fifo_write_q [RESP_DEPTH];
  logic                  fifo_err_q   [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q  [RESP_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [31:0]      req_count_q, req_count_d;
  logic [15:0]      err_count_q, err_count_d;

  assign push           = pipe_valid_q[LATENCY-1];
  assign noc_resp_valid = (count_q != '0);
  assign pop            = noc_resp_valid && noc_resp_ready;
  assign noc_req_ready  = (inflight_q < CNT_W'(RESP_DEPTH));
  assign accept         = noc_req_valid && noc_req_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]    <= pipe_id_q[LATENCY-1];
      fifo_write_q[wr_ptr_q] <= pipe_write_q[LATENCY-1];
      fifo_err_q[wr_ptr_q]   <= pipe_err_q[LATENCY-1];
      fifo_data_q[wr_ptr_q]  <= tail_data;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    req_count_d = accept ? req_count_q + 32'd1 : req_count_q;
    err_count_d = err_count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({accept, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    if (push && pipe_err_q[LATENCY-1] && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      req_count_q <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      req_count_q <= req_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign noc_resp_id    = noc_resp_valid ? fifo_id_q[rd_ptr_q]    : '0;
  assign noc_resp_write = noc_resp_valid ? fifo_write_q[rd_ptr_q] : 1'b0;
  assign noc_resp_data  = noc_resp_valid ? fifo_data_q[rd_ptr_q]  : '0;
  assign noc_resp_err   = (noc_resp_valid && fifo_err_q[rd_ptr_q]) ? 2'b10 : 2'b00;

  assign inflight  = inflight_q;
  assign req_count = req_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_nebula_noc_mem_target.sv
// Directed testbench for nebula_noc_mem_target (default parameters:
// 512-bit data, 256 words, latency 2, 4 response credits).
module tb_nebula_noc_mem_target;

  logic         clk;
  logic         rst_n;
  logic         noc_req_valid;
  logic         noc_req_ready;
  logic         noc_req_write;
  logic [63:0]  noc_req_addr;
  logic [7:0]   noc_req_id;
  logic [511:0] noc_req_data;
  logic [63:0]  noc_req_strb;
  logic         noc_resp_valid;
  logic         noc_resp_ready;
  logic [7:0]   noc_resp_id;
  logic         noc_resp_write;
  logic [511:0] noc_resp_data;
  logic [1:0]   noc_resp_err;
  logic [2:0]   inflight;
  logic [31:0]  req_count;
  logic [15:0]  err_count;

  nebula_noc_mem_target dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .noc_req_valid  (noc_req_valid),
    .noc_req_ready  (noc_req_ready),
    .noc_req_write  (noc_req_write),
    .noc_req_addr   (noc_req_addr),
    .noc_req_id     (noc_req_id),
    .noc_req_data   (noc_req_data),
    .noc_req_strb   (noc_req_strb),
    .noc_resp_valid (noc_resp_valid),
    .noc_resp_ready (noc_resp_ready),
    .noc_resp_id    (noc_resp_id),
    .noc_resp_write (noc_resp_write),
    .noc_resp_data  (noc_resp_data),
    .noc_resp_err   (noc_resp_err),
    .inflight       (inflight),
    .req_count      (req_count),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   id;
    logic         w;
    logic [511:0] d;
    logic [1:0]   e;
  } exp_t;

  int           errors = 0;
  int           checks = 0;
  int           req_exp = 0;
  int           err_exp = 0;
  int           inf_exp = 0;
  int           accepted;
  int           sent;
  int           tx_id;
  logic         acc;
  logic         pop;
  logic         stale;
  logic [511:0] ones;
  logic [511:0] pat_p;
  logic [511:0] pat_q;
  logic [511:0] mdl [256];
  exp_t         sb [$];
  exp_t         e_item;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One accepted request (caller guarantees a credit is available).
  task automatic req(input logic w, input logic [63:0] a, input logic [7:0] id,
                     input logic [511:0] d, input logic [63:0] s);
    noc_req_valid = 1'b1;
    noc_req_write = w;
    noc_req_addr  = a;
    noc_req_id    = id;
    noc_req_data  = d;
    noc_req_strb  = s;
    cyc();
    noc_req_valid = 1'b0;
    req_exp++;
  endtask

  // Waits (bounded) for a response, checks it, and lets it pop.
  task automatic expect_resp(input string tag, input logic [7:0] id, input logic w,
                             input logic [511:0] d, input logic [1:0] e);
    int n = 0;
    while (!noc_resp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, " valid"}, 512'(noc_resp_valid), 512'(1));
    chk({tag, " id"},    512'(noc_resp_id),    512'(id));
    chk({tag, " write"}, 512'(noc_resp_write), 512'(w));
    chk({tag, " data"},  noc_resp_data,        d);
    chk({tag, " err"},   512'(noc_resp_err),   512'(e));
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ones  = '1;
    pat_p = {16{32'hDEADBEEF}};
    pat_q = {16{32'h1234_5678}};
    rst_n = 1'b1;
    noc_req_valid = 1'b0;
    noc_req_write = 1'b0;
    noc_req_addr  = '0;
    noc_req_id    = '0;
    noc_req_data  = '0;
    noc_req_strb  = '0;
    noc_resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) cyc();

    // Reset values
    chk("rst req_ready",  512'(noc_req_ready),  512'(1));
    chk("rst resp_valid", 512'(noc_resp_valid), 512'(0));
    chk("rst resp_id",    512'(noc_resp_id),    512'(0));
    chk("rst resp_data",  noc_resp_data,        512'(0));
    chk("rst resp_err",   512'(noc_resp_err),   512'(0));
    chk("rst inflight",   512'(inflight),       512'(0));
    chk("rst req_count",  512'(req_count),      512'(0));
    chk("rst err_count",  512'(err_count),      512'(0));
    rst_n = 1'b1;
    cyc();

    // Write then read, with latency check on the write response
    noc_req_valid = 1'b1;
    noc_req_write = 1'b1;
    noc_req_addr  = 64'h1000;
    noc_req_id    = 8'h01;
    noc_req_data  = ones;
    noc_req_strb  = '1;
    cyc();
    noc_req_valid = 1'b0;
    req_exp++;
    chk("t1 valid at k",   512'(noc_resp_valid), 512'(0));
    cyc();
    chk("t1 valid at k+1", 512'(noc_resp_valid), 512'(0));
    cyc();
    chk("t1 valid at k+2", 512'(noc_resp_valid), 512'(1));
    chk("t1 wr id",        512'(noc_resp_id),    512'(8'h01));
    chk("t1 wr write",     512'(noc_resp_write), 512'(1));
    chk("t1 wr err",       512'(noc_resp_err),   512'(0));
    chk("t1 wr data",      noc_resp_data,        512'(0));
    req(1'b0, 64'h1000, 8'h02, '0, '0);
    expect_resp("t1 rd", 8'h02, 1'b0, ones, 2'b00);
    chk("t1 req_count", 512'(req_count), 512'(req_exp));

    // Strobe merge
    req(1'b1, 64'h40, 8'h03, '0, '1);
    expect_resp("t2 wr0", 8'h03, 1'b1, '0, 2'b00);
    req(1'b1, 64'h40, 8'h04, ones, 64'h0F);
    expect_resp("t2 wr1", 8'h04, 1'b1, '0, 2'b00);
    req(1'b0, 64'h40, 8'h05, '0, '0);
    expect_resp("t2 rd", 8'h05, 1'b0, 512'hFFFF_FFFF, 2'b00);

    // Out of range: 0x10000 aliases word 0 but must not touch it
    req(1'b1, 64'h0, 8'h20, pat_p, '1);
    expect_resp("t3 wr word0", 8'h20, 1'b1, '0, 2'b00);
    req(1'b0, 64'h10000, 8'h07, '0, '0);
    err_exp++;
    expect_resp("t3 oor rd", 8'h07, 1'b0, '0, 2'b10);
    chk("t3 err_count 1", 512'(err_count), 512'(err_exp));
    req(1'b1, 64'h10000, 8'h08, '0, '1);
    err_exp++;
    expect_resp("t3 oor wr", 8'h08, 1'b1, '0, 2'b10);
    chk("t3 err_count 2", 512'(err_count), 512'(err_exp));
    req(1'b0, 64'h0, 8'h09, '0, '0);
    expect_resp("t3 word0 intact", 8'h09, 1'b0, pat_p, 2'b00);
    chk("t3 req_count", 512'(req_count), 512'(req_exp));

    // Backpressure: 6 reads with the consumer stalled
    noc_resp_ready = 1'b0;
    accepted = 0;
    noc_req_valid = 1'b1;
    noc_req_write = 1'b0;
    noc_req_addr  = 64'h1000;
    for (int i = 0; i < 6; i++) begin
      noc_req_id = 8'h10 + 8'(accepted);
      if (noc_req_ready) accepted++;
      cyc();
    end
    req_exp += accepted;
    chk("t4 accepted",      512'(accepted),       512'(4));
    chk("t4 req_ready",     512'(noc_req_ready),  512'(0));
    chk("t4 inflight",      512'(inflight),       512'(4));
    chk("t4 held id",       512'(noc_resp_id),    512'(8'h10));
    noc_resp_ready = 1'b1;
    inf_exp = 4;
    for (int j = 0; j < 6; j++) begin
      chk("t4 drain valid",    512'(noc_resp_valid), 512'(1));
      chk("t4 drain id",       512'(noc_resp_id),    512'(8'h10 + j));
      chk("t4 drain data",     noc_resp_data,        ones);
      chk("t4 drain inflight", 512'(inflight),       512'(inf_exp));
      acc = noc_req_valid && noc_req_ready;
      cyc();
      inf_exp = inf_exp + int'(acc) - 1;
      if (acc) begin
        accepted++;
        req_exp++;
        if (accepted == 6) noc_req_valid = 1'b0;
        else noc_req_id = 8'h10 + 8'(accepted);
      end
    end
    chk("t4 all accepted", 512'(accepted), 512'(6));
    chk("t4 inflight end", 512'(inflight), 512'(0));

    // Random streaming against a scoreboard; words 0..3 initialised first
    for (int w = 0; w < 4; w++) begin
      mdl[w] = rnd512();
      req(1'b1, 64'(w) << 6, 8'h60 + 8'(w), mdl[w], '1);
      expect_resp("t5 init", 8'h60 + 8'(w), 1'b1, '0, 2'b00);
    end
    sent = 0;
    tx_id = 0;
    inf_exp = 0;
    for (int c = 0; c < 3000 && (sent < 50 || sb.size() != 0); c++) begin
      if (!noc_req_valid && tx_id < 50 && $urandom_range(0, 3) != 0) begin
        noc_req_write = 1'($urandom_range(0, 1));
        noc_req_addr  = (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) noc_req_addr = noc_req_addr | (64'h1 << $urandom_range(20, 60));
        noc_req_id    = 8'h80 + 8'(tx_id);
        noc_req_data  = rnd512();
        noc_req_strb  = {$urandom, $urandom};
        noc_req_valid = 1'b1;
        tx_id++;
      end
      noc_resp_ready = ($urandom_range(0, 3) != 0);
      pop = noc_resp_valid && noc_resp_ready;
      acc = noc_req_valid && noc_req_ready;
      chk("t5 inflight", 512'(inflight), 512'(inf_exp));
      if (pop) begin
        if (sb.size() == 0) begin
          chk("t5 unexpected resp", 512'(noc_resp_valid), 512'(0));
        end else begin
          e_item = sb.pop_front();
          chk("t5 id",    512'(noc_resp_id),    512'(e_item.id));
          chk("t5 write", 512'(noc_resp_write), 512'(e_item.w));
          chk("t5 data",  noc_resp_data,        e_item.d);
          chk("t5 err",   512'(noc_resp_err),   512'(e_item.e));
        end
      end
      if (acc) begin
        e_item.id = noc_req_id;
        e_item.w  = noc_req_write;
        e_item.e  = (|noc_req_addr[63:14]) ? 2'b10 : 2'b00;
        if (e_item.e != 2'b00) begin
          err_exp++;
          e_item.d = '0;
        end else if (noc_req_write) begin
          for (int b = 0; b < 64; b++)
            if (noc_req_strb[b]) mdl[noc_req_addr[13:6]][b*8 +: 8] = noc_req_data[b*8 +: 8];
          e_item.d = '0;
        end else begin
          e_item.d = mdl[noc_req_addr[13:6]];
        end
        sb.push_back(e_item);
        sent++;
        req_exp++;
      end
      inf_exp = inf_exp + int'(acc) - int'(pop);
      cyc();
      if (acc) noc_req_valid = 1'b0;
    end
    noc_resp_ready = 1'b1;
    chk("t5 inflight end",  512'(inflight),       512'(0));
    chk("t5 resp idle",     512'(noc_resp_valid), 512'(0));
    chk("t5 req_count",     512'(req_count),      512'(req_exp));
    chk("t5 err_count",     512'(err_count),      512'(err_exp));

    // Reset with 3 requests in flight
    req(1'b1, 64'h80, 8'h21, pat_q, '1);
    expect_resp("t6 wr", 8'h21, 1'b1, '0, 2'b00);
    noc_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      noc_req_valid = 1'b1;
      noc_req_write = 1'b0;
      noc_req_addr  = 64'h0;
      noc_req_id    = 8'h30 + 8'(i);
      cyc();
    end
    noc_req_valid = 1'b0;
    chk("t6 inflight pre", 512'(inflight),       512'(3));
    chk("t6 valid pre",    512'(noc_resp_valid), 512'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6 rst req_ready",  512'(noc_req_ready),  512'(1));
    chk("t6 rst resp_valid", 512'(noc_resp_valid), 512'(0));
    chk("t6 rst resp_id",    512'(noc_resp_id),    512'(0));
    chk("t6 rst resp_write", 512'(noc_resp_write), 512'(0));
    chk("t6 rst resp_data",  noc_resp_data,        512'(0));
    chk("t6 rst resp_err",   512'(noc_resp_err),   512'(0));
    chk("t6 rst inflight",   512'(inflight),       512'(0));
    chk("t6 rst req_count",  512'(req_count),      512'(0));
    chk("t6 rst err_count",  512'(err_count),      512'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    noc_resp_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stale = stale | noc_resp_valid;
      cyc();
    end
    chk("t6 no stale resp", 512'(stale), 512'(0));
    req_exp = 0;
    req(1'b0, 64'h80, 8'h40, '0, '0);
    expect_resp("t6 rd after reset", 8'h40, 1'b0, pat_q, 2'b00);
    chk("t6 req_count", 512'(req_count), 512'(req_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
